// File: rtl/seout_demux.sv
// Receive-side demux for the serialized update stream: steers each 64-bit
// update to one of eight per-lane FIFOs and drains each lane independently.
module seout_demux #(
  parameter int FIFO_DEPTH   = 8,
  parameter int STALL_THRESH = FIFO_DEPTH - 2,
  parameter int LANE_SEL_LSB = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] input_word,
  input  logic        input_valid,
  input  logic        lane_stall0,
  input  logic        lane_stall1,
  input  logic        lane_stall2,
  input  logic        lane_stall3,
  input  logic        lane_stall4,
  input  logic        lane_stall5,
  input  logic        lane_stall6,
  input  logic        lane_stall7,
  output logic [63:0] output_update0,
  output logic [63:0] output_update1,
  output logic [63:0] output_update2,
  output logic [63:0] output_update3,
  output logic [63:0] output_update4,
  output logic [63:0] output_update5,
  output logic [63:0] output_update6,
  output logic [63:0] output_update7,
  output logic        output_valid0,
  output logic        output_valid1,
  output logic        output_valid2,
  output logic        output_valid3,
  output logic        output_valid4,
  output logic        output_valid5,
  output logic        output_valid6,
  output logic        output_valid7,
  output logic        ge_stall_request,
  output logic        overflow
);

  localparam int NL    = 8;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [63:0]      in_word_q;
  logic             in_valid_q;
  logic [2:0]       sel_s;
  logic [NL-1:0]    stall_s;
  logic [NL-1:0]    full_s;
  logic [NL-1:0]    pop_s;
  logic [NL-1:0]    push_s;
  logic [NL-1:0]    ovf_hit_s;
  logic [63:0]      mem_q    [NL][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [NL];
  logic [PTR_W-1:0] rd_ptr_q [NL];
  logic [CNT_W-1:0] cnt_q    [NL];
  logic [CNT_W-1:0] cnt_d    [NL];
  logic [63:0]      upd_q    [NL];
  logic [NL-1:0]    vld_q;
  logic             stall_req_q;
  logic             stall_req_d;
  logic             ovf_q;
  logic             ovf_d;

  assign stall_s = {lane_stall7, lane_stall6, lane_stall5, lane_stall4,
                    lane_stall3, lane_stall2, lane_stall1, lane_stall0};
  assign sel_s   = in_word_q[LANE_SEL_LSB +: 3];

  // Per-lane push/pop decisions, occupancy next-state and stall/overflow flags.
  always_comb begin
    stall_req_d = 1'b0;
    ovf_d       = ovf_q;
    full_s      = {NL{1'b0}};
    pop_s       = {NL{1'b0}};
    push_s      = {NL{1'b0}};
    ovf_hit_s   = {NL{1'b0}};
    for (int l = 0; l < NL; l++) begin
      cnt_d[l]  = cnt_q[l];
      full_s[l] = (cnt_q[l] == CNT_W'(FIFO_DEPTH));
      pop_s[l]  = (cnt_q[l] != {CNT_W{1'b0}}) && !stall_s[l];
      // A full lane still takes the word when its head leaves on the same edge.
      if (in_valid_q && (sel_s == 3'(l))) begin
        push_s[l]    = !full_s[l] || pop_s[l];
        ovf_hit_s[l] = full_s[l] && !pop_s[l];
      end else begin
        push_s[l]    = 1'b0;
        ovf_hit_s[l] = 1'b0;
      end
      case ({push_s[l], pop_s[l]})
        2'b10:   cnt_d[l] = cnt_q[l] + CNT_W'(1);
        2'b01:   cnt_d[l] = cnt_q[l] - CNT_W'(1);
        default: cnt_d[l] = cnt_q[l];
      endcase
      if (cnt_q[l] >= CNT_W'(STALL_THRESH)) begin
        stall_req_d = 1'b1;
      end else begin
        stall_req_d = stall_req_d;
      end
    end
    if (|ovf_hit_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Lane FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    for (int l = 0; l < NL; l++) begin
      if (push_s[l]) begin
        mem_q[l][wr_ptr_q[l]] <= in_word_q;
      end
    end
  end

  // Input stage, pointers, occupancy and registered lane outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_word_q   <= 64'd0;
      in_valid_q  <= 1'b0;
      vld_q       <= {NL{1'b0}};
      stall_req_q <= 1'b0;
      ovf_q       <= 1'b0;
      for (int l = 0; l < NL; l++) begin
        wr_ptr_q[l] <= {PTR_W{1'b0}};
        rd_ptr_q[l] <= {PTR_W{1'b0}};
        cnt_q[l]    <= {CNT_W{1'b0}};
        upd_q[l]    <= 64'd0;
      end
    end else begin
      in_word_q   <= input_word;
      in_valid_q  <= input_valid;
      vld_q       <= pop_s;
      stall_req_q <= stall_req_d;
      ovf_q       <= ovf_d;
      for (int l = 0; l < NL; l++) begin
        cnt_q[l] <= cnt_d[l];
        if (push_s[l]) begin
          wr_ptr_q[l] <= wr_ptr_q[l] + PTR_W'(1);
        end
        if (pop_s[l]) begin
          rd_ptr_q[l] <= rd_ptr_q[l] + PTR_W'(1);
          upd_q[l]    <= mem_q[l][rd_ptr_q[l]];
        end
      end
    end
  end

  assign output_update0   = upd_q[0];
  assign output_update1   = upd_q[1];
  assign output_update2   = upd_q[2];
  assign output_update3   = upd_q[3];
  assign output_update4   = upd_q[4];
  assign output_update5   = upd_q[5];
  assign output_update6   = upd_q[6];
  assign output_update7   = upd_q[7];
  assign output_valid0    = vld_q[0];
  assign output_valid1    = vld_q[1];
  assign output_valid2    = vld_q[2];
  assign output_valid3    = vld_q[3];
  assign output_valid4    = vld_q[4];
  assign output_valid5    = vld_q[5];
  assign output_valid6    = vld_q[6];
  assign output_valid7    = vld_q[7];
  assign ge_stall_request = stall_req_q;
  assign overflow         = ovf_q;

endmodule

// File: tb/tb_seout_demux.sv
// Directed and randomized bench for seout_demux, checked every cycle against a
// queue-based model of the per-lane buffering rules.
module tb_seout_demux;

  localparam int DEPTH  = 8;
  localparam int THRESH = DEPTH - 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] iw;
  logic        iv;
  logic [7:0]  ls;
  logic [63:0] ou [8];
  logic [7:0]  ov;
  logic        gsr;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0] mq [8][$];
  logic        st_v;
  logic [63:0] st_w;
  logic [63:0] exp_upd [8];
  logic [7:0]  exp_vld;
  logic        exp_stall;
  logic        exp_ovf;

  always #5 clk = ~clk;

  seout_demux dut (
    .clk(clk), .rst(rst), .input_word(iw), .input_valid(iv),
    .lane_stall0(ls[0]), .lane_stall1(ls[1]), .lane_stall2(ls[2]), .lane_stall3(ls[3]),
    .lane_stall4(ls[4]), .lane_stall5(ls[5]), .lane_stall6(ls[6]), .lane_stall7(ls[7]),
    .output_update0(ou[0]), .output_update1(ou[1]), .output_update2(ou[2]), .output_update3(ou[3]),
    .output_update4(ou[4]), .output_update5(ou[5]), .output_update6(ou[6]), .output_update7(ou[7]),
    .output_valid0(ov[0]), .output_valid1(ov[1]), .output_valid2(ov[2]), .output_valid3(ov[3]),
    .output_valid4(ov[4]), .output_valid5(ov[5]), .output_valid6(ov[6]), .output_valid7(ov[7]),
    .ge_stall_request(gsr), .overflow(ovf)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one clock edge to the model using the inputs present before the edge.
  task automatic model_edge();
    logic nstall;
    int   lane;
    if (rst) begin
      for (int l = 0; l < 8; l++) begin
        mq[l].delete();
        exp_upd[l] = 64'd0;
      end
      exp_vld = 8'd0; exp_stall = 1'b0; exp_ovf = 1'b0;
      st_v = 1'b0; st_w = 64'd0;
    end else begin
      nstall = 1'b0;
      for (int l = 0; l < 8; l++)
        if (mq[l].size() >= THRESH) nstall = 1'b1;
      for (int l = 0; l < 8; l++) begin
        if (mq[l].size() > 0 && !ls[l]) begin
          exp_upd[l] = mq[l].pop_front();
          exp_vld[l] = 1'b1;
        end else begin
          exp_vld[l] = 1'b0;
        end
      end
      if (st_v) begin
        lane = int'(st_w[34:32]);
        if (mq[lane].size() < DEPTH) mq[lane].push_back(st_w);
        else exp_ovf = 1'b1;
      end
      exp_stall = nstall;
      st_v = iv;
      st_w = iw;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    for (int l = 0; l < 8; l++) begin
      chk($sformatf("valid%0d", l), {63'd0, ov[l]}, {63'd0, exp_vld[l]});
      chk($sformatf("update%0d", l), ou[l], exp_upd[l]);
    end
    chk("ge_stall_request", {63'd0, gsr}, {63'd0, exp_stall});
    chk("overflow", {63'd0, ovf}, {63'd0, exp_ovf});
  endtask

  task automatic send(input logic [31:0] id, input logic [31:0] val);
    iw = {id, val};
    iv = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    iv = 1'b0;
    iw = 64'd0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      iv = 1'b1;
      iw = {$urandom, $urandom};
      tick();
    end
    rst = 1'b0;
    iv = 1'b0;
  endtask

  initial begin
    int   sent;
    logic seen;
    rst = 1'b1; iv = 1'b0; iw = 64'd0; ls = 8'd0;
    st_v = 1'b0; st_w = 64'd0;

    // Reset with valid input held high
    do_reset(3);
    idle(2);

    // Routing across all lanes, no stalls
    for (int i = 0; i < 8; i++) send(32'hA + 32'(i), 32'hA + 32'(i));
    idle(4);
    chk("route_lane2_word", ou[2], 64'h0000000A_0000000A);
    chk("route_lane0_word", ou[0], 64'h00000010_00000010);

    // Lane 1 ordering
    for (int i = 0; i < 5; i++) send(32'h1 + 32'(8 * i), 32'h100 + 32'(i));
    idle(4);
    chk("lane1_last", ou[1], 64'h00000021_00000104);

    // Stall lane 4 and honour back-pressure
    ls[4] = 1'b1;
    sent = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (gsr) begin
        seen = 1'b1;
      end else begin
        send(32'h4 + 32'(8 * sent), 32'h400 + 32'(sent));
        sent++;
      end
    end
    chk("stall_seen", {63'd0, seen}, 64'd1);
    idle(3);
    ls[4] = 1'b0;
    idle(12);
    chk("lane4_no_overflow", {63'd0, ovf}, 64'd0);

    // Overflow on lane 5 ignoring stall request
    ls[5] = 1'b1;
    for (int i = 0; i < 10; i++) send(32'h5, 32'h500 + 32'(i));
    idle(3);
    chk("overflow_set", {63'd0, ovf}, 64'd1);
    ls[5] = 1'b0;
    idle(12);
    chk("lane5_last_kept", ou[5], 64'h00000005_00000507);
    chk("overflow_sticky", {63'd0, ovf}, 64'd1);

    // Push and pop on the same edge while lane 6 is full
    do_reset(1);
    ls[6] = 1'b1;
    for (int i = 0; i < 8; i++) send(32'h6, 32'h600 + 32'(i));
    idle(2);
    send(32'h6, 32'h608);
    ls[6] = 1'b0;
    idle(12);
    chk("lane6_wrap_last", ou[6], 64'h00000006_00000608);
    chk("lane6_no_overflow", {63'd0, ovf}, 64'd0);

    // Randomized traffic with random lane stalls, back-pressure honoured
    do_reset(1);
    for (int i = 0; i < 300; i++) begin
      for (int l = 0; l < 8; l++) ls[l] = ($urandom_range(3) == 0);
      if (!gsr && $urandom_range(9) < 7) send($urandom, $urandom);
      else idle(1);
    end
    ls = 8'd0;
    idle(12);
    chk("random_no_overflow", {63'd0, ovf}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
